// File: rtl/core_pkg.sv
// Core-wide sizing constants plus the common-data-bus request record,
// requester ids and the round-robin wrap helper shared by the CDB arbiter.
package core_pkg;

   localparam int ISSUE_WIDTH = 2;
   localparam int PREGS       = 64;
   localparam int ROB_ENTRIES = 32;
   localparam int PTAG_W      = $clog2(PREGS);
   localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);

   localparam int CDB_NUM_REQ = 4;
   localparam logic [1:0] CDB_ALU0 = 2'd0;
   localparam logic [1:0] CDB_ALU1 = 2'd1;
   localparam logic [1:0] CDB_BR   = 2'd2;
   localparam logic [1:0] CDB_LSU  = 2'd3;

   typedef struct packed {
      logic [PTAG_W-1:0]    tag;
      logic [31:0]          value;
      logic [ROB_IDX_W-1:0] rob;
   } cdb_req_t;

   // Callers never exceed 2*n-1, so a single conditional subtract suffices.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Small per-requester result buffer: DEPTH entries, strict FIFO order,
// flush clears occupancy without touching storage.
module cdb_req_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : (p + PTR_W'(1));
   endfunction

   // Storage write; data needs no reset because count gates its use.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers completed results per functional unit and
// broadcasts up to CDB_W of them per cycle in round-robin order.
module cdb_arbiter
   import core_pkg::*;
#(
   parameter  int NUM_REQ = CDB_NUM_REQ,
   parameter  int CDB_W   = ISSUE_WIDTH,
   parameter  int TAG_W   = $clog2(PREGS),
   parameter  int ROB_W   = $clog2(ROB_ENTRIES),
   parameter  int DEPTH   = 2,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
   input  logic [NUM_REQ-1:0][31:0]         req_value,
   input  logic [NUM_REQ-1:0][ROB_W-1:0]    req_rob,
   output logic [CDB_W-1:0]                 cdb_valid,
   output logic [CDB_W-1:0][TAG_W-1:0]      cdb_tag,
   output logic [CDB_W-1:0][31:0]           cdb_value,
   output logic [CDB_W-1:0][ROB_W-1:0]      cdb_rob,
   output logic [CDB_W-1:0][SRC_W-1:0]      cdb_src
);

   localparam int ENT_W = TAG_W + 32 + ROB_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [NUM_REQ-1:0][CNT_W-1:0] count_s;
   logic [NUM_REQ-1:0][ENT_W-1:0] head_s;
   logic [NUM_REQ-1:0][ENT_W-1:0] cand_s;
   logic [NUM_REQ-1:0]            buffered_s;
   logic [NUM_REQ-1:0]            fire_s;
   logic [NUM_REQ-1:0]            cand_vld_s;
   logic [NUM_REQ-1:0]            grant_s;
   logic [NUM_REQ-1:0]            pop_s;
   logic [NUM_REQ-1:0]            push_s;
   logic [CDB_W-1:0]              slot_vld_s;
   logic [CDB_W-1:0][ENT_W-1:0]   slot_ent_s;
   logic [CDB_W-1:0][SRC_W-1:0]   slot_src_s;
   logic [SRC_W-1:0]              rr_ptr_r;
   logic [SRC_W-1:0]              rr_next_s;

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
      cdb_req_fifo #(
         .DEPTH (DEPTH),
         .W     (ENT_W)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .flush (flush),
         .push  (push_s[r]),
         .pop   (pop_s[r]),
         .din   ({req_tag[r], req_value[r], req_rob[r]}),
         .head  (head_s[r]),
         .count (count_s[r])
      );
   end

   // Per-requester candidate: the buffered head is always older than a new push.
   always_comb begin
      req_ready  = '0;
      buffered_s = '0;
      fire_s     = '0;
      cand_vld_s = '0;
      cand_s     = '0;
      pop_s      = '0;
      push_s     = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         buffered_s[r] = (count_s[r] != '0);
         req_ready[r]  = (count_s[r] < CNT_W'(DEPTH));
         fire_s[r]     = req_valid[r] && req_ready[r] && !flush;
         cand_vld_s[r] = buffered_s[r] || fire_s[r];
         if (buffered_s[r]) begin
            cand_s[r] = head_s[r];
         end else begin
            cand_s[r] = {req_tag[r], req_value[r], req_rob[r]};
         end
         pop_s[r]  = grant_s[r] && buffered_s[r];
         push_s[r] = fire_s[r] && !(grant_s[r] && !buffered_s[r]);
      end
   end

   // Round-robin scan from rr_ptr filling slots in discovery order.
   always_comb begin
      int               n;
      logic [SRC_W-1:0] idx;
      grant_s    = '0;
      slot_vld_s = '0;
      slot_ent_s = '0;
      slot_src_s = '0;
      rr_next_s  = rr_ptr_r;
      n          = 0;
      idx        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = SRC_W'(rr_wrap(int'(rr_ptr_r) + i, NUM_REQ));
         if (cand_vld_s[idx] && (n < CDB_W)) begin
            grant_s[idx] = 1'b1;
            for (int s = 0; s < CDB_W; s++) begin
               if (n == s) begin
                  slot_vld_s[s] = 1'b1;
                  slot_ent_s[s] = cand_s[idx];
                  slot_src_s[s] = idx;
               end else begin
                  slot_vld_s[s] = slot_vld_s[s];
               end
            end
            if (int'(idx) == NUM_REQ - 1) begin
               rr_next_s = '0;
            end else begin
               rr_next_s = idx + SRC_W'(1);
            end
            n = n + 1;
         end else begin
            n = n;
         end
      end
   end

   // Broadcast register and round-robin pointer; flush behaves like reset here.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rr_ptr_r  <= '0;
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_rob   <= '0;
         cdb_src   <= '0;
      end else begin
         rr_ptr_r  <= rr_next_s;
         cdb_valid <= slot_vld_s;
         cdb_src   <= slot_src_s;
         for (int s = 0; s < CDB_W; s++) begin
            {cdb_tag[s], cdb_value[s], cdb_rob[s]} <= slot_ent_s[s];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_cdb_arbiter;
   import core_pkg::*;

   localparam int NR = 4;
   localparam int CW = 2;
   localparam int TW = $clog2(PREGS);
   localparam int RW = $clog2(ROB_ENTRIES);
   localparam int DP = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic [NR-1:0]          req_valid = '0;
   logic [NR-1:0]          req_ready;
   logic [NR-1:0][TW-1:0]  req_tag   = '0;
   logic [NR-1:0][31:0]    req_value = '0;
   logic [NR-1:0][RW-1:0]  req_rob   = '0;
   logic [CW-1:0]          cdb_valid;
   logic [CW-1:0][TW-1:0]  cdb_tag;
   logic [CW-1:0][31:0]    cdb_value;
   logic [CW-1:0][RW-1:0]  cdb_rob;
   logic [CW-1:0][1:0]     cdb_src;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(NR), .CDB_W(CW), .TAG_W(TW), .ROB_W(RW), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_tag(req_tag), .req_value(req_value), .req_rob(req_rob),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_rob(cdb_rob), .cdb_src(cdb_src)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: one queue per requester holding everything accepted but
   // not yet broadcast (bypass is simply a queue of length one).
   cdb_req_t     mq [NR][$];
   int           rr_m = 0;
   logic [CW-1:0] e_valid = '0;
   cdb_req_t     e_ent [CW];
   int           e_src [CW];
   int           m_slot;
   int           m_r;
   cdb_req_t     m_e;

   initial begin
      for (int s = 0; s < CW; s++) begin
         e_ent[s] = '0;
         e_src[s] = 0;
      end
   end

   always @(posedge clk) begin
      if (reset || flush) begin
         for (int r = 0; r < NR; r++) mq[r].delete();
         rr_m    = 0;
         e_valid = '0;
         for (int s = 0; s < CW; s++) begin
            e_ent[s] = '0;
            e_src[s] = 0;
         end
      end else begin
         for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && mq[r].size() < DP) begin
               m_e.tag   = req_tag[r];
               m_e.value = req_value[r];
               m_e.rob   = req_rob[r];
               mq[r].push_back(m_e);
            end
         end
         e_valid = '0;
         for (int s = 0; s < CW; s++) begin
            e_ent[s] = '0;
            e_src[s] = 0;
         end
         m_slot = 0;
         for (int i = 0; i < NR; i++) begin
            m_r = (rr_m + i) % NR;
            if (m_slot < CW && mq[m_r].size() > 0) begin
               e_ent[m_slot]   = mq[m_r].pop_front();
               e_src[m_slot]   = m_r;
               e_valid[m_slot] = 1'b1;
               m_slot++;
            end
         end
         if (m_slot > 0) rr_m = (e_src[m_slot-1] + 1) % NR;
      end
   end

   // Every-cycle comparison against the model, plus fairness/leak monitors.
   logic chk_en = 1'b0;
   logic sat_phase = 1'b0;
   logic after_flush = 1'b0;
   logic leak = 1'b0;
   int   gap = 0;
   int   max_gap = 0;
   logic [NR-1:0] exp_rdy;
   logic lsu_seen;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int r = 0; r < NR; r++) exp_rdy[r] = (mq[r].size() < DP);
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
         for (int s = 0; s < CW; s++) begin
            chk($sformatf("cdb_tag[%0d]", s),   64'(cdb_tag[s]),   64'(e_ent[s].tag));
            chk($sformatf("cdb_value[%0d]", s), 64'(cdb_value[s]), 64'(e_ent[s].value));
            chk($sformatf("cdb_rob[%0d]", s),   64'(cdb_rob[s]),   64'(e_ent[s].rob));
            chk($sformatf("cdb_src[%0d]", s),   64'(cdb_src[s]),   64'(e_src[s]));
         end
         if (sat_phase) begin
            lsu_seen = 1'b0;
            for (int s = 0; s < CW; s++)
               if (cdb_valid[s] && cdb_src[s] == 2'd3) lsu_seen = 1'b1;
            gap = lsu_seen ? 0 : gap + 1;
            if (gap > max_gap) max_gap = gap;
         end
         if (after_flush) begin
            for (int s = 0; s < CW; s++)
               if (cdb_valid[s] && (cdb_value[s][31:28] == 4'h2 || cdb_value[s] == 32'hF1F1_F1F1))
                  leak = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [TW-1:0] t, input logic [31:0] v, input logic [RW-1:0] rb);
      req_valid[r] = 1'b1;
      req_tag[r]   = t;
      req_value[r] = v;
      req_rob[r]   = rb;
   endtask

   int   lsu_seq = 0;
   logic seen_full = 1'b0;
   logic lsu_fire;

   task automatic sat_cycle(input int c);
      set_req(0, TW'(1), 32'h1000_0000 + 32'(c), RW'(c));
      set_req(1, TW'(2), 32'h3000_0000 + 32'(c), RW'(c + 1));
      set_req(2, TW'(3), 32'h2000_0000 + 32'(c), RW'(c + 2));
      set_req(3, TW'(4), 32'h4000_0000 + 32'(lsu_seq), RW'(lsu_seq));
      if (!req_ready[3]) seen_full = 1'b1;
      lsu_fire = req_ready[3];
      tick();
      if (lsu_fire) lsu_seq++;
   endtask

   initial begin
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("idle_req_ready", 64'(req_ready), 64'hF);
      chk("idle_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);

      // All four push together: 0,1 first, then buffered 2,3.
      for (int r = 0; r < NR; r++) set_req(r, TW'(10 + r), 32'hA000_0000 + 32'(r), RW'(r));
      tick();
      req_valid = '0;
      chk("all4_c1_valid", 64'(cdb_valid), 64'h3);
      chk("all4_c1_src0", 64'(cdb_src[0]), 64'd0);
      chk("all4_c1_src1", 64'(cdb_src[1]), 64'd1);
      chk("all4_c1_val1", 64'(cdb_value[1]), 64'hA000_0001);
      tick();
      chk("all4_c2_valid", 64'(cdb_valid), 64'h3);
      chk("all4_c2_src0", 64'(cdb_src[0]), 64'd2);
      chk("all4_c2_val1", 64'(cdb_value[1]), 64'hA000_0003);
      tick();
      chk("all4_c3_valid", 64'(cdb_valid), 64'h0);
      chk("all4_c3_ready", 64'(req_ready), 64'hF);

      // Single ALU0 push, one-cycle latency.
      set_req(0, TW'(7), 32'hDEAD_BEEF, RW'(3));
      tick();
      req_valid = '0;
      chk("single_valid", 64'(cdb_valid), 64'h1);
      chk("single_tag", 64'(cdb_tag[0]), 64'd7);
      chk("single_value", 64'(cdb_value[0]), 64'hDEAD_BEEF);
      chk("single_rob", 64'(cdb_rob[0]), 64'd3);
      chk("single_src", 64'(cdb_src[0]), 64'd0);
      chk("single_slot1_value", 64'(cdb_value[1]), 64'd0);
      tick();

      // Saturation: LSU pushes every cycle against three busy units.
      for (int c = 0; c < 12; c++) begin
         sat_cycle(c);
         if (c == 0) sat_phase = 1'b1;
      end
      sat_phase = 1'b0;
      chk("lsu_reached_full", 64'(seen_full), 64'd1);
      chk("lsu_fair_gap_le1", 64'(max_gap <= 1), 64'd1);

      // Flush with BR holding two entries and an ALU1 push in the same cycle.
      for (int k = 0; k < 8; k++) begin
         if (!req_ready[2]) break;
         sat_cycle(12 + k);
      end
      chk("br_full_before_flush", 64'(req_ready[2]), 64'd0);
      req_valid = '0;
      flush = 1'b1;
      set_req(1, TW'(5), 32'hF1F1_F1F1, RW'(9));
      tick();
      flush = 1'b0;
      req_valid = '0;
      chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("flush_req_ready", 64'(req_ready), 64'hF);
      chk("flush_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);
      after_flush = 1'b1;
      repeat (4) tick();
      after_flush = 1'b0;
      chk("flush_no_leak", 64'(leak), 64'd0);

      // Reset pulse with full buffers, then a fresh push.
      for (int c = 0; c < 6; c++) sat_cycle(40 + c);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_valid = '0;
      chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("rst_cdb_value0", 64'(cdb_value[0]), 64'd0);
      chk("rst_cdb_tag1", 64'(cdb_tag[1]), 64'd0);
      chk("rst_cdb_src1", 64'(cdb_src[1]), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'hF);
      chk("rst_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);
      set_req(1, TW'(9), 32'h1234_5678, RW'(5));
      tick();
      req_valid = '0;
      chk("post_rst_valid", 64'(cdb_valid), 64'h1);
      chk("post_rst_src", 64'(cdb_src[0]), 64'd1);
      chk("post_rst_tag", 64'(cdb_tag[0]), 64'd9);
      chk("post_rst_value", 64'(cdb_value[0]), 64'h1234_5678);
      chk("post_rst_rob", 64'(cdb_rob[0]), 64'd5);
      tick();
      tick();
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
